// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

    // Access size encodings on req_size (2'b11 is illegal)
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} lsu_state_t;

    // Request fields kept for the life of one transaction.
    // The word index is held separately because its width depends on LARGO.
    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [1:0]  off;
        logic [31:0] wdata;
    } lsu_req_t;

endpackage

// File: rtl/lsu_align.sv
// Lane steering for sub-word accesses: load extract/extend and store merge.
// Purely combinational, little-endian.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int ANCHO = 32
) (
    input  logic [ANCHO-1:0] ld_word,
    input  logic [1:0]       off,
    input  logic [1:0]       size,
    input  logic             uns,
    output logic [ANCHO-1:0] ld_data,
    input  logic [ANCHO-1:0] old_word,
    input  logic [ANCHO-1:0] wdata,
    output logic [ANCHO-1:0] st_word
);

    logic [ANCHO/8-1:0][7:0]   ld_b;
    logic [ANCHO/16-1:0][15:0] ld_h;
    logic [7:0]                b;
    logic [15:0]               h;

    assign ld_b = ld_word;
    assign ld_h = ld_word;
    assign b    = ld_b[off];
    assign h    = ld_h[off[1]];

    // Pick the addressed lane and sign- or zero-extend it
    always_comb begin
        ld_data = ld_word;
        case (size)
            SZ_B:    ld_data = {{(ANCHO-8){~uns & b[7]}}, b};
            SZ_H:    ld_data = {{(ANCHO-16){~uns & h[15]}}, h};
            default: ld_data = ld_word;
        endcase
    end

    logic [ANCHO/8-1:0][7:0]   st_b;
    logic [ANCHO/16-1:0][15:0] st_h;

    // Replace the addressed lane of the old word with the low store bits
    always_comb begin
        st_b    = old_word;
        st_h    = old_word;
        st_word = old_word;
        case (size)
            SZ_B: begin
                st_b[off] = wdata[7:0];
                st_word   = st_b;
            end
            SZ_H: begin
                st_h[off[1]] = wdata[15:0];
                st_word      = st_h;
            end
            default: st_word = wdata;
        endcase
    end

endmodule

// File: rtl/lsu_rmw.sv
// Load/store unit between MEM stage and a word-wide RAM.
// Sub-word stores are done as read-modify-write; bad requests never touch RAM.
module lsu_rmw
    import lsu_pkg::*;
#(
    parameter int ANCHO = 32,
    parameter int LARGO = 1024,
    localparam int AW   = $clog2(LARGO)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [1:0]       req_size,
    input  logic             req_unsigned,
    input  logic [31:0]      req_addr,
    input  logic [ANCHO-1:0] req_wdata,
    output logic             resp_valid,
    output logic [ANCHO-1:0] resp_rdata,
    output logic             resp_err,
    output logic             ram_we,
    output logic             ram_re,
    output logic [AW-1:0]    ram_addr,
    output logic [ANCHO-1:0] ram_din,
    input  logic [ANCHO-1:0] ram_dout
);

    lsu_state_t       state, state_nxt;
    lsu_req_t         lat;
    logic [AW-1:0]    idx;
    logic [ANCHO-1:0] merged;
    logic [ANCHO-1:0] ld_data, st_word;
    logic             accept, bad_req, word_st;

    assign accept  = req_valid & req_ready;
    assign word_st = lat.we & (lat.size == SZ_W);

    // Illegal size, misalignment, or any address bit above the RAM range
    assign bad_req = (req_size == 2'b11)
                   | ((req_size == SZ_H) & req_addr[0])
                   | ((req_size == SZ_W) & (req_addr[1:0] != 2'b00))
                   | (|req_addr[31:AW+2]);

    assign ram_addr = idx;

    lsu_align #(.ANCHO(ANCHO)) u_align (
        .ld_word  (ram_dout),
        .off      (lat.off),
        .size     (lat.size),
        .uns      (lat.uns),
        .ld_data  (ld_data),
        .old_word (ram_dout),
        .wdata    (lat.wdata),
        .st_word  (st_word)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state and state-decoded RAM/handshake strobes
    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        ram_re     = 1'b0;
        ram_we     = 1'b0;
        ram_din    = '0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = bad_req ? RESP : ACCESS;
            end
            ACCESS: begin
                ram_re = 1'b1;
                if (word_st) begin
                    ram_we    = 1'b1;
                    ram_din   = lat.wdata;
                    state_nxt = RESP;
                end else if (lat.we) begin
                    state_nxt = WRITE;
                end else begin
                    state_nxt = RESP;
                end
            end
            WRITE: begin
                ram_we    = 1'b1;
                ram_din   = merged;
                state_nxt = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request latch, merge buffer and response registers; response fields
    // only change on the edge that moves into RESP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat        <= '0;
            idx        <= '0;
            merged     <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        lat.we    <= req_we;
                        lat.size  <= req_size;
                        lat.uns   <= req_unsigned;
                        lat.off   <= req_addr[1:0];
                        lat.wdata <= req_wdata;
                        idx       <= req_addr[AW+1:2];
                        if (bad_req) begin
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end
                    end
                end
                ACCESS: begin
                    if (!lat.we) begin
                        resp_rdata <= ld_data;
                        resp_err   <= 1'b0;
                    end else if (word_st) begin
                        resp_rdata <= '0;
                        resp_err   <= 1'b0;
                    end else begin
                        merged <= st_word;
                    end
                end
                WRITE: begin
                    resp_rdata <= '0;
                    resp_err   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/lsu_rmw.md
Name: lsu_rmw

Overview:
- Load/store unit between the core's MEM stage and the word-wide data RAM (async read, sync write, word-addressed).
- Accepts byte/half/word loads and stores on byte addresses, and sign/zero-extends load data.
- Performs sub-word stores as read-modify-write.
- Flags misaligned or out-of-range accesses without touching memory.

Parameters:
- ANCHO, 32, data word width in bits; only 32 is supported.
- LARGO, 1024, RAM depth in words; RAM index width is $clog2(LARGO).

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  core presents a request
- req_ready  out  1  unit can accept a request (high only in IDLE)
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0
- req_addr  in  32  byte address
- req_wdata  in  ANCHO  store data, right-aligned
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  ANCHO  extended load data; 0 for stores and errors
- resp_err  out  1  misaligned, illegal size or out of range; valid with resp_valid
- ram_we  out  1  RAM write enable
- ram_re  out  1  RAM read enable
- ram_addr  out  $clog2(LARGO)  RAM word index, taken from req_addr[$clog2(LARGO)+1:2]
- ram_din  out  ANCHO  RAM write data
- ram_dout  in  ANCHO  RAM read data, combinational from ram_addr

Behaviour:
- Reset, asynchronous, while rst_n=0:
  - state=IDLE.
  - resp_valid=0, resp_err=0, resp_rdata=0.
  - ram_we=0, ram_re=0, ram_addr=0, ram_din=0.
  - All latched request fields are cleared.
- Reset mid-operation:
  - ram_we drops immediately.
  - An RMW aborted before WRITE leaves the RAM unchanged.
  - No response is issued.
- Handshake:
  - A request is accepted on a clk edge where req_valid & req_ready.
  - All req_* fields are latched at acceptance.
  - resp_valid is a single-cycle pulse with no backpressure.
  - req_ready=0 from acceptance until the cycle after resp_valid.
- FSM states:
  - IDLE: req_ready=1. On accept: if error, go to RESP with err=1; otherwise go to ACCESS.
  - ACCESS: ram_re=1, ram_addr = latched index.
    - Load: extract the lane from ram_dout, extend it, register into resp_rdata, go to RESP.
    - Word store: ram_we=1, ram_din=wdata, go to RESP.
    - Sub-word store: register merged word = ram_dout with the selected lane replaced by wdata[7:0] or wdata[15:0], go to WRITE.
  - WRITE: ram_we=1, ram_re=0, ram_din = merged word, go to RESP.
  - RESP: resp_valid=1, go to IDLE.
- Error conditions, evaluated at accept:
  - size=11.
  - half with addr[0]=1.
  - word with addr[1:0]!=0.
  - addr[31:$clog2(LARGO)+2] != 0.
  - On error: no RAM access of any kind, resp_rdata=0.
- Lane select:
  - byte uses lane addr[1:0], bits [8*k+7:8*k].
  - half uses addr[1], bits [16*h+15:16*h].
  - Little-endian.
- Latency from the accept edge to resp_valid high:
  - error: 1 cycle
  - load: 2 cycles
  - word store: 2 cycles
  - sub-word store: 3 cycles
- ram_re and ram_we are decoded from state only; never both 1 in WRITE.
- ram_din=0 whenever ram_we=0.
- In IDLE and RESP: ram_re=0, ram_we=0.
- resp_err and resp_rdata hold their value until the next response; they are only meaningful while resp_valid=1.

Decomposition:
- Package lsu_pkg holds:
  - size constants SZ_B=2'b00, SZ_H=2'b01, SZ_W=2'b10.
  - state enum lsu_state_t {IDLE, ACCESS, WRITE, RESP}.
- One purely combinational sub-module, lsu_align, provides:
  - load_extract(word, addr[1:0], size, unsigned) -> ANCHO.
  - store_merge(old, wdata, addr[1:0], size) -> ANCHO.
  - It is unit-tested separately.

Test Plan:
- Preset word 3 = 0x8844_22F1; load byte, signed, addr 0x0C -> resp at cycle 2, rdata=0xFFFF_FFF1, err=0. Unsigned half at 0x0E -> 0x0000_8844.
- Store byte 0xAB at 0x0D over 0x1122_3344 -> ram_re in cycle 1, ram_we in cycle 2 with din 0x1122_AB44, resp at cycle 3; a subsequent word load returns 0x1122_AB44.
- Word store 0xDEAD_BEEF at 0x10 -> single ram_we cycle (cycle 1), ram_addr=4, resp at cycle 2, err=0.
- Misaligned/illegal cases:
  - word load at 0x02 -> resp_err=1 at cycle 1, ram_re/ram_we never asserted.
  - half at 0x01 -> same.
  - size=11 -> same.
  - addr 0x1000 with LARGO=1024 -> same.
- Back-to-back: req_valid held high with two loads -> second accepted only in the cycle after the first resp_valid; req_ready low throughout.
- Pull rst_n low during the ACCESS cycle of a byte store -> outputs reset immediately, no ram_we ever asserted, target word unchanged, req_ready=1 after release.
